torus_array_seq: RTL
====================

Name: torus_array_seq

Overview:
- Job sequencer for an N x N weight-stationary systolic array built from PEs with a shared B/partial-sum bus.
- Accepts a job start, then runs the B-load phase: drives the array's load_B and pulls N B rows from the B source.
- Then streams M A vectors, producing skewed per-lane A enables and per-column partial-sum valid strobes.
- Waits for the array to drain, then signals done. The array itself is free-running; the sequencer only tags and paces data.

Parameters:
- N_p, 4, array dimension (rows = columns = N_p); N_p >= 2.
- rows_width_p, 16, width of the A-row count M.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_v_i  in  1  job request valid.
- num_rows_i  in  rows_width_p  M = number of A vectors in the job; captured on start handshake.
- start_ready_o  out  1  sequencer can accept a job.
- b_v_i  in  1  B row available from the B source.
- b_yumi_o  out  1  B row consumed this cycle.
- load_b_o  out  1  drives array load_B; high exactly on cycles a B row is consumed.
- a_v_i  in  1  A vector available.
- a_yumi_o  out  1  A vector consumed this cycle.
- a_lane_en_o  out  N_p  per-row skewed A-valid enables to the array's A skew buffer.
- ps_v_o  out  N_p  per-column partial-sum valid; not backpressurable.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse at job completion.

Behaviour:
- States: IDLE, LOAD_B, STREAM, DRAIN, DONE.
- Reset: async assert forces IDLE and clears the B counter, row counter, M register and acc_sr (width 2*N_p).
  - All outputs are 0 while reset is high; start_ready_o = (state==IDLE) & ~reset.
  - Reset mid-job abandons the job with no done_o.
- IDLE:
  - start_ready_o = 1.
  - On start_v_i & start_ready_o: capture M, clear counters, go to LOAD_B.
  - b_v_i and a_v_i are ignored (no yumi).
- LOAD_B:
  - b_yumi_o = load_b_o = b_v_i (combinational).
  - Bubbles on b_v_i stall the phase with load_b_o = 0.
  - After the N_p-th consumed row: go to STREAM if M != 0, else go to DONE.
  - a_v_i is ignored in this state.
- STREAM:
  - a_yumi_o = a_v_i. Bubbles are allowed and are carried as zeros in acc_sr.
  - After the M-th accepted vector: go to DRAIN.
- acc_sr (shifts every cycle in every state):
  - Update: acc_sr[0] <= a_yumi_o; acc_sr[k] <= acc_sr[k-1].
  - a_lane_en_o[r] = acc_sr[r]: row r is enabled r+1 cycles after the accept.
  - ps_v_o[c] = acc_sr[N_p+c]: column c result is valid N_p+1+c cycles after the accept.
- DRAIN: when acc_sr == 0, go to DONE.
- DONE: done_o = 1 for one cycle, then go to IDLE. start_ready_o = 0 in DONE.
- Row counter width is rows_width_p; M up to 2^rows_width_p - 1 with no wrap.
- Start during a busy state: not accepted, since start_ready_o = 0.

Test Plan (N_p=4):
- Reset: with reset high and no clock edges, all outputs are 0 and busy_o = 0. After release, start_ready_o = 1.
- Full-rate job, M=3: start accepted at cycle S; b_v_i held high gives load_b_o/b_yumi_o high S+1..S+4. A accepts at T=S+5..S+7.
  - a_lane_en_o[0] high T+1..T+3.
  - ps_v_o[0] high T+5..T+7; ps_v_o[3] high T+8..T+10.
  - done_o at T+12 only.
- B bubbles: b_v_i = 1,0,1,0,1,1 gives exactly 4 b_yumi_o pulses that mirror load_b_o, then STREAM.
- A bubbles, M=2: a_v_i = 1,0,1 gives a 1-cycle gap in a_lane_en_o[r] and ps_v_o[c]. done_o fires 1 cycle later than the gapless case.
- M=0: LOAD_B completes, then DONE. No a_yumi_o, a_lane_en_o or ps_v_o activity; done_o fires 1 cycle after the 4th B row.
- Async reset mid-STREAM (M=5, after 2 accepts): outputs are 0 immediately and no done_o occurs. A new start with M=1 then completes normally.
- start_v_i held through a job is accepted only in IDLE. a_v_i high during LOAD_B produces no a_yumi_o.

Source files
------------

// File: rtl/torus_array_seq.sv
// torus_array_seq: job sequencer for an N_p x N_p weight-stationary systolic
// array. Each job first loads N_p B rows, then streams M A vectors. It
// generates skewed per-row A enables and per-column partial-sum valid strobes,
// waits for the array to drain, and then pulses done.
//
// Ports:
//   clk_i, reset          clock, asynchronous active-high reset
//   start_v_i/num_rows_i  job request and its A-row count M (captured on accept)
//   start_ready_o         sequencer idle and able to take a job
//   b_v_i/b_yumi_o        B-row source handshake; load_b_o mirrors b_yumi_o
//   a_v_i/a_yumi_o        A-vector source handshake
//   a_lane_en_o           per-row skewed A enables
//   ps_v_o                per-column partial-sum valid strobes
//   busy_o, done_o        job in progress / one-cycle completion pulse
module torus_array_seq #(
  parameter int unsigned N_p          = 4,
  parameter int unsigned rows_width_p = 16
) (
  input  logic                    clk_i,
  input  logic                    reset,
  input  logic                    start_v_i,
  input  logic [rows_width_p-1:0] num_rows_i,
  output logic                    start_ready_o,
  input  logic                    b_v_i,
  output logic                    b_yumi_o,
  output logic                    load_b_o,
  input  logic                    a_v_i,
  output logic                    a_yumi_o,
  output logic [N_p-1:0]          a_lane_en_o,
  output logic [N_p-1:0]          ps_v_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned acc_w   = 2 * N_p;
  localparam int unsigned b_cnt_w = $clog2(N_p);

  localparam logic [2:0] st_idle   = 3'd0;
  localparam logic [2:0] st_load_b = 3'd1;
  localparam logic [2:0] st_stream = 3'd2;
  localparam logic [2:0] st_drain  = 3'd3;
  localparam logic [2:0] st_done   = 3'd4;

  logic [2:0]              state_q,   state_d;
  logic [b_cnt_w-1:0]      b_cnt_q,   b_cnt_d;
  logic [rows_width_p-1:0] row_cnt_q, row_cnt_d;
  logic [rows_width_p-1:0] m_q,       m_d;
  logic [acc_w-1:0]        acc_sr_q,  acc_sr_d;

  logic start_rdy_c;
  logic b_take_c;
  logic a_take_c;
  logic done_c;

  // Next-state, counters and handshakes
  always_comb begin
    state_d     = state_q;
    b_cnt_d     = b_cnt_q;
    row_cnt_d   = row_cnt_q;
    m_d         = m_q;
    start_rdy_c = 1'b0;
    b_take_c    = 1'b0;
    a_take_c    = 1'b0;
    done_c      = 1'b0;

    case (state_q)
      st_idle: begin
        start_rdy_c = 1'b1;
        if (start_v_i) begin
          m_d       = num_rows_i;
          b_cnt_d   = '0;
          row_cnt_d = '0;
          state_d   = st_load_b;
        end
      end
      st_load_b: begin
        b_take_c = b_v_i;
        if (b_v_i) begin
          if (b_cnt_q == b_cnt_w'(N_p - 1)) begin
            state_d = (m_q != '0) ? st_stream : st_done;
          end else begin
            b_cnt_d = b_cnt_q + b_cnt_w'(1);
          end
        end
      end
      st_stream: begin
        // m_q is nonzero here, so m_q - 1 cannot underflow
        a_take_c = a_v_i;
        if (a_v_i) begin
          if (row_cnt_q == m_q - rows_width_p'(1)) begin
            state_d = st_drain;
          end else begin
            row_cnt_d = row_cnt_q + rows_width_p'(1);
          end
        end
      end
      st_drain: begin
        if (acc_sr_q == '0) state_d = st_done;
      end
      st_done: begin
        done_c  = 1'b1;
        state_d = st_idle;
      end
      default: state_d = st_idle;
    endcase

    // Accept history shifts every cycle; bubbles enter as zeros
    acc_sr_d = {acc_sr_q[acc_w-2:0], a_take_c};
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q   <= st_idle;
      b_cnt_q   <= '0;
      row_cnt_q <= '0;
      m_q       <= '0;
      acc_sr_q  <= '0;
    end else begin
      state_q   <= state_d;
      b_cnt_q   <= b_cnt_d;
      row_cnt_q <= row_cnt_d;
      m_q       <= m_d;
      acc_sr_q  <= acc_sr_d;
    end
  end

  // Every output is forced low while reset is asserted
  assign start_ready_o = start_rdy_c & ~reset;
  assign b_yumi_o      = b_take_c & ~reset;
  assign load_b_o      = b_take_c & ~reset;
  assign a_yumi_o      = a_take_c & ~reset;
  assign a_lane_en_o   = reset ? '0 : acc_sr_q[N_p-1:0];
  assign ps_v_o        = reset ? '0 : acc_sr_q[acc_w-1:N_p];
  assign busy_o        = (state_q != st_idle) & ~reset;
  assign done_o        = done_c & ~reset;

endmodule
